seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_sub_borrow.sv | 24 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package seq_divider_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_sub_borrow.sv
// Ripple-borrow subtractor: diff_o = a_i - b_i, borrow_o set when a_i < b_i.
module sub_borrow #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] bchain;

  // Chain of full-subtractor cells, LSB first.
  always_comb begin
    bchain    = '0;
    diff_o    = '0;
    for (int i = 0; i < N; i++) begin
      diff_o[i]   = a_i[i] ^ b_i[i] ^ bchain[i];
      bchain[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & bchain[i]);
    end
    borrow_o = bchain[N];
  end

endmodule : sub_borrow

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one shift-subtract step per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RW    = WIDTH + 1;

  state_e           state_q, state_d;
  logic [RW-1:0]    r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [RW-1:0]    t_c;
  logic [RW-1:0]    diff_c;
  logic             borrow_c;

  // Partial remainder shifted left with the next dividend bit; R's MSB is always 0 between steps.
  assign t_c = RW'({r_q, q_q[WIDTH-1]});

  sub_borrow #(.N(RW)) u_sub (
    .a_i      (t_c),
    .b_i      ({1'b0, d_q}),
    .diff_o   (diff_c),
    .borrow_o (borrow_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CALC;
          end else begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        busy_d = 1'b1;
        r_d    = borrow_c ? t_c : diff_c;
        q_d    = {q_q[WIDTH-2:0], ~borrow_c};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quot_d  = {q_q[WIDTH-2:0], ~borrow_c};
          rem_d   = r_d[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider
